// File: rtl/branch_predictor_if.sv
// Fetch/resolve-side bundle for the branch predictor: lookup request and response,
// training strobe and the misprediction counter.
interface branch_predictor_if;
    logic [31:0] pc;
    logic        pred_control;
    logic [31:0] pred_branch;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic [31:0] mispred_cnt;

    modport master (
        output pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred,
        input  pred_control, pred_branch, mispred_cnt
    );

    modport slave (
        input  pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred,
        output pred_control, pred_branch, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup against
// registered state, trained by the resolving stage on the clock edge.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic               CLK,
    input  logic               RST,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic        valid_q  [ENTRIES];
    logic        valid_d  [ENTRIES];
    tag_t        tag_q    [ENTRIES];
    tag_t        tag_d    [ENTRIES];
    logic [31:0] target_q [ENTRIES];
    logic [31:0] target_d [ENTRIES];
    logic [1:0]  ctr_q    [ENTRIES];
    logic [1:0]  ctr_d    [ENTRIES];
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    idx_t lk_idx_s;
    tag_t lk_tag_s;
    logic lk_hit_s;
    logic pred_control_s;
    idx_t up_idx_s;
    tag_t up_tag_s;
    logic up_hit_s;
    logic unused_s;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        case (c)
            2'b00:   sat_inc = 2'b01;
            2'b01:   sat_inc = 2'b10;
            2'b10:   sat_inc = 2'b11;
            2'b11:   sat_inc = 2'b11;
            default: sat_inc = 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        case (c)
            2'b00:   sat_dec = 2'b00;
            2'b01:   sat_dec = 2'b00;
            2'b10:   sat_dec = 2'b01;
            2'b11:   sat_dec = 2'b10;
            default: sat_dec = 2'b01;
        endcase
    endfunction

    assign unused_s = ^{bp.pc[1:0], bp.upd_pc[1:0]};

    // Lookup sees only registered state, so a same-cycle update is visible next cycle.
    always_comb begin
        lk_idx_s       = bp.pc[IDX_W+1:2];
        lk_tag_s       = bp.pc[31:IDX_W+2];
        lk_hit_s       = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
        pred_control_s = lk_hit_s & ctr_q[lk_idx_s][1];
    end

    assign bp.pred_control = pred_control_s;
    assign bp.pred_branch  = pred_control_s ? target_q[lk_idx_s] : 32'h0000_0000;
    assign bp.mispred_cnt  = cnt_q;

    // Training next-state: hit adjusts the counter, taken miss allocates at weak-T.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        cnt_d    = cnt_q;
        up_idx_s = bp.upd_pc[IDX_W+1:2];
        up_tag_s = bp.upd_pc[31:IDX_W+2];
        up_hit_s = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
        if (bp.upd_en) begin
            if (up_hit_s) begin
                if (bp.upd_taken) begin
                    ctr_d[up_idx_s]    = sat_inc(ctr_q[up_idx_s]);
                    target_d[up_idx_s] = bp.upd_target;
                end else begin
                    ctr_d[up_idx_s]    = sat_dec(ctr_q[up_idx_s]);
                end
            end else if (bp.upd_taken) begin
                valid_d[up_idx_s]  = 1'b1;
                tag_d[up_idx_s]    = up_tag_s;
                target_d[up_idx_s] = bp.upd_target;
                ctr_d[up_idx_s]    = 2'b10;
            end else begin
                ctr_d = ctr_q;
            end
            if (bp.upd_mispred && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_d = cnt_q + 32'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset wins over a simultaneous training strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0000_0000;
                ctr_q[i]    <= 2'b01;
            end
            cnt_q <= 32'h0000_0000;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed test-plan sequences followed by
// random traffic, checked against a behavioural BTB model.
module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);

    typedef struct {
        logic        ctl;
        logic [31:0] br;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    bit          m_valid [ENTRIES];
    longint      m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_str   [ENTRIES];
    longint      m_cnt;

    always #5 clk = ~clk;

    branch_predictor_if bp_if();

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .CLK (clk),
        .RST (rst),
        .bp  (bp_if)
    );

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % ENTRIES);
    endfunction

    function automatic longint tag_of(input logic [31:0] a);
        return longint'(a >> (IDX_W + 2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'h0;
            m_str[i]   = 1;
        end
        m_cnt = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, record the expected response, then advance the model.
    task automatic step(input logic r, input logic [31:0] p, input logic en,
                        input logic [31:0] up, input logic tk, input logic [31:0] tg,
                        input logic mp);
        exp_t e;
        int   i;
        bit   hit;
        @(posedge clk);
        #1;
        rst                = r;
        bp_if.pc           = p;
        bp_if.upd_en       = en;
        bp_if.upd_pc       = up;
        bp_if.upd_taken    = tk;
        bp_if.upd_target   = tg;
        bp_if.upd_mispred  = mp;
        i     = idx_of(p);
        hit   = m_valid[i] && (m_tag[i] == tag_of(p));
        e.ctl = hit && (m_str[i] >= 2);
        e.br  = e.ctl ? m_tgt[i] : 32'h0;
        e.cnt = m_cnt[31:0];
        sb_q.push_back(e);
        if (r) begin
            model_reset();
        end else if (en) begin
            if (mp && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            i   = idx_of(up);
            hit = m_valid[i] && (m_tag[i] == tag_of(up));
            if (hit && tk) begin
                m_str[i] = (m_str[i] < 3) ? m_str[i] + 1 : 3;
                m_tgt[i] = tg;
            end else if (hit) begin
                m_str[i] = (m_str[i] > 0) ? m_str[i] - 1 : 0;
            end else if (tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(up);
                m_tgt[i]   = tg;
                m_str[i]   = 2;
            end
        end
    endtask

    task automatic look(input logic [31:0] p);
        step(1'b0, p, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic train(input logic [31:0] up, input logic tk, input logic [31:0] tg);
        step(1'b0, 32'h40, 1'b1, up, tk, tg, 1'b0);
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pred_control", {31'd0, bp_if.pred_control}, {31'd0, e.ctl});
                chk("pred_branch", bp_if.pred_branch, e.br);
                chk("mispred_cnt", bp_if.mispred_cnt, e.cnt);
            end
        end
    end

    initial begin
        logic [31:0] p;
        logic [31:0] up;
        int          drain;
        rst               = 1'b1;
        bp_if.pc          = 32'h0;
        bp_if.upd_en      = 1'b0;
        bp_if.upd_pc      = 32'h0;
        bp_if.upd_taken   = 1'b0;
        bp_if.upd_target  = 32'h0;
        bp_if.upd_mispred = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        look(32'h40);
        // Same-cycle lookup and first allocation, then visible next cycle.
        step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        look(32'h40);
        train(32'h40, 1'b0, 32'h0);
        look(32'h40);
        train(32'h40, 1'b0, 32'h0);
        look(32'h40);
        train(32'h40, 1'b1, 32'h100);
        look(32'h40);
        train(32'h40, 1'b1, 32'h100);
        look(32'h40);
        repeat (4) train(32'h40, 1'b1, 32'h100);
        train(32'h40, 1'b0, 32'h0);
        look(32'h40);
        // Aliasing on index 0.
        train(32'h440, 1'b1, 32'h200);
        look(32'h40);
        look(32'h440);
        look(32'h443);
        // Not-taken miss must not allocate.
        train(32'h80, 1'b0, 32'h999);
        look(32'h80);
        // Mispredict counting; strobe without upd_en is ignored.
        repeat (3) step(1'b0, 32'h440, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h440, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        look(32'h440);
        // Reset beats a simultaneous allocation.
        step(1'b1, 32'h440, 1'b1, 32'h84, 1'b1, 32'h300, 1'b1);
        look(32'h440);
        look(32'h84);

        for (int n = 0; n < 3000; n++) begin
            p  = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2)
                 | 32'($urandom_range(0, 3));
            up = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2)
                 | 32'($urandom_range(0, 3));
            step(($urandom_range(0, 199) == 0), p, ($urandom_range(0, 2) != 0), up,
                 ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 3) == 0));
        end

        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating counters.
- Supplies pred_control and pred_branch to the fetch stage for the current PC.
- Trained by the resolving stage (execute/memory) once a branch or jump outcome is known.
- Lookup is combinational against registered state. Training writes on the clock edge.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, at least 2.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous active-high reset
- pc  input  32  current fetch PC (word_t)
- pred_control  output  1  1 = fetch takes pred_branch as next PC
- pred_branch  output  32  predicted target (word_t)
- upd_en  input  1  training strobe for one resolved control-flow instruction
- upd_pc  input  32  PC of the resolved instruction
- upd_taken  input  1  actual outcome
- upd_target  input  32  actual taken target
- upd_mispred  input  1  resolving stage flagged a misprediction (flush issued)
- mispred_cnt  output  32  saturating count of cycles with upd_en & upd_mispred

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] is ignored.
  - upd_pc is split the same way.
- Entry state: valid (1), tag, target (32), ctr (2).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational):
  - hit = valid[index] & (tag[index] == pc tag).
  - pred_control = hit & ctr[index][1].
  - pred_branch = target[index] when pred_control = 1, else 32'h0.
- Training (registered, only when upd_en = 1):
  - Update hit, taken: ctr = sat_inc(ctr), target <= upd_target.
  - Update hit, not taken: ctr = sat_dec(ctr), target unchanged.
  - Update miss, taken: allocate (replace) entry; valid = 1, tag = upd tag, target = upd_target, ctr = 10.
  - Update miss, not taken: no state change.
  - Saturation: 11 + inc = 11; 00 − dec = 00.
- upd_en = 0: no state changes.
- Same-cycle lookup and update to the same index:
  - Lookup returns the pre-update state.
  - No bypass; the new state is visible from the next cycle.
- mispred_cnt:
  - Increments by 1 on each cycle with upd_en & upd_mispred.
  - Holds at 32'hFFFFFFFF.
  - upd_mispred without upd_en is ignored.
- Reset (RST = 1 at a CLK edge):
  - All valid = 0, ctr = 01, target = 0, tag = 0, mispred_cnt = 0.
  - Hence pred_control = 0 and pred_branch = 32'h0 after reset.
  - Reset takes priority over a simultaneous upd_en; that update is lost.
- Predictor does not observe fetch stall or flush.
  - Fetch gates use of the prediction with ihit.
  - Stalls do not alter predictor state.
- Aliasing: two PCs with the same index evict each other. Only the newest taken branch stays resident.

Test Plan:
- Reset, then pc = 32'h0000_0040 -> pred_control = 0, pred_branch = 0, mispred_cnt = 0.
- upd_en with upd_pc = 32'h0000_0040, taken, target 32'h0000_0100 -> next cycle pc = 0x40 gives pred_control = 1, pred_branch = 0x100 (ctr = 10).
- Two not-taken updates on 0x40 (10 -> 01 -> 00) -> pred_control = 0 after the first. Then one taken update (00 -> 01) -> pred_control still 0. Second taken -> pred_control = 1.
- Four taken updates to 0x40 -> ctr saturates at 11. One not-taken -> still predicts taken (10).
- Train 0x40 taken to 0x100, then train 0x440 (same index 0, different tag) taken to 0x200 -> pc = 0x40 misses (pred_control = 0); pc = 0x440 gives 0x200.
- Not-taken update to untrained 0x80 -> no allocation; pc = 0x80 gives pred_control = 0.
- Same cycle: pc = 0x40 lookup plus first taken training of 0x40 -> pred_control = 0 that cycle, 1 the next.
- Three cycles upd_en & upd_mispred, one cycle upd_mispred only -> mispred_cnt = 3.
- RST asserted with upd_en -> all predictions cleared; entry not allocated.
